// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-memory fetch handshake between sequencer (master) and memory (slave).
interface cpu_sequencer_if #(parameter int PC_WIDTH = 32);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic                ack;
  logic [31:0]         rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning pc and instr.
// Optional CPU_SEQ_HALT_EN: a jump-to-self retires once and then parks in HALT until reset.
module cpu_sequencer #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  cpu_sequencer_if.master     imem,
  output logic [31:0]         instr,
  input  logic                dec_jump,
  input  logic                dec_branch,
  input  logic [31:0]         dec_jump_address,
  input  logic                dec_write_enable,
  input  logic [31:0]         alu_result,
  output logic                rf_we,
  output logic [PC_WIDTH-1:0] pc,
  output logic                retired,
  output logic                halted
);
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, WRITEBACK
`ifdef CPU_SEQ_HALT_EN
    , HALT
`endif
  } state_t;
  state_t state, state_d;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] target;
  logic unused;
  assign target = dec_jump_address[PC_WIDTH-1:0];
  assign unused = ^alu_result[31:1];
  assign imem.req = state == FETCH;
  assign imem.addr = pc;
`ifdef CPU_SEQ_HALT_EN
  logic halt_q;
  assign halted = state == HALT;
`else
  assign halted = 1'b0;
`endif
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = run ? FETCH : IDLE;
      FETCH:     state_d = imem.ack ? DECODE : FETCH;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = WRITEBACK;
`ifdef CPU_SEQ_HALT_EN
      WRITEBACK: state_d = halt_q ? HALT : run ? FETCH : IDLE;
      HALT:      state_d = HALT;
`else
      WRITEBACK: state_d = run ? FETCH : IDLE;
`endif
      default:   state_d = IDLE;
    endcase
  end
  // rf_we/retired are registered on entry to WRITEBACK so outputs stay Moore
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      next_pc <= RESET_PC;
      instr   <= '0;
      rf_we   <= 1'b0;
      retired <= 1'b0;
`ifdef CPU_SEQ_HALT_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      rf_we   <= state == EXECUTE && dec_write_enable && !dec_jump && !dec_branch;
      retired <= state == EXECUTE;
      if (state == FETCH && imem.ack) instr <= imem.rdata;
      if (state == EXECUTE) next_pc <= (dec_jump || (dec_branch && alu_result[0])) ? target : pc + 1'b1;
      if (state == WRITEBACK) pc <= next_pc;
`ifdef CPU_SEQ_HALT_EN
      if (state == EXECUTE) halt_q <= dec_jump && target == pc;
`endif
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench with a retirement scoreboard (expected rf_we and next pc per instruction).
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst_n, run;
  logic [31:0] instr, dec_jump_address, alu_result;
  logic dec_jump, dec_branch, dec_write_enable, rf_we, retired, halted;
  logic [31:0] pc;
  logic [31:0] mem [64];
  int ack_lat;
  int wait_cnt;
  int tests = 0;
  int fails = 0;
  typedef struct { logic [31:0] pc; logic we; } exp_t;
  exp_t sb [$];
  logic pend;
  logic [31:0] pend_pc;
  cpu_sequencer_if #(.PC_WIDTH(32)) imem ();
  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem(imem), .instr(instr),
    .dec_jump(dec_jump), .dec_branch(dec_branch), .dec_jump_address(dec_jump_address),
    .dec_write_enable(dec_write_enable), .alu_result(alu_result),
    .rf_we(rf_we), .pc(pc), .retired(retired), .halted(halted)
  );
  always #5 clk = ~clk;
  // memory with programmable ack latency (0 = ack combinational from req)
  always @(posedge clk) wait_cnt <= imem.req ? wait_cnt + 1 : 0;
  assign imem.ack = imem.req && (wait_cnt >= ack_lat);
  assign imem.rdata = mem[imem.addr[5:0]];
  // minimal decoder: opcode 0 R-type, 2 J, 5 BNE (absolute word target)
  assign dec_jump = instr[31:26] == 6'h02;
  assign dec_branch = instr[31:26] == 6'h05;
  assign dec_write_enable = instr[31:26] == 6'h00;
  assign dec_jump_address = dec_branch ? {16'h0, instr[15:0]} : {6'h0, instr[25:0]};
  assign alu_result = {31'h0, pc == 32'h10};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      pend = 1'b0;
    end else if (retired) begin
      chk("sb_pop", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rf_we", 32'(rf_we), 32'(e.we));
        pend = 1'b1;
        pend_pc = e.pc;
      end
    end else if (pend) begin
      chk("sb_pc", pc, pend_pc);
      pend = 1'b0;
    end
  end
  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    mem[0] = 32'h00221820; mem[1] = 32'h08000010; mem[16] = 32'h14220020;
    mem[32] = 32'h14220020; mem[33] = 32'h00221820; mem[34] = 32'h00221820;
    rst_n = 1'b0; run = 1'b0; ack_lat = 0; pend = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem.req), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    sb.push_back('{32'h1, 1'b1});
    sb.push_back('{32'h10, 1'b0});
    sb.push_back('{32'h20, 1'b0});
    sb.push_back('{32'h21, 1'b0});
    sb.push_back('{32'h22, 1'b1});
    sb.push_back('{32'h23, 1'b1});
    rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
    chk("r_req_c1", 32'(imem.req), 32'd1);
    chk("r_addr_c1", imem.addr, 32'd0);
    @(negedge clk);
    chk("r_instr_c2", instr, 32'h00221820);
    chk("r_req_c2", 32'(imem.req), 32'd0);
    repeat (2) @(negedge clk);
    chk("r_retired_c4", 32'(retired), 32'd1);
    chk("r_rf_we_c4", 32'(rf_we), 32'd1);
    @(negedge clk);
    chk("r_pc_c5", pc, 32'd1);
    chk("r_req_c5", 32'(imem.req), 32'd1);
    chk("r_addr_c5", imem.addr, 32'd1);
    repeat (4) @(negedge clk);
    chk("j_addr", imem.addr, 32'h10);
    chk("j_req", 32'(imem.req), 32'd1);
    repeat (4) @(negedge clk);
    chk("bne_taken_pc", pc, 32'h20);
    repeat (3) @(negedge clk);
    chk("bne_nt_retired", 32'(retired), 32'd1);
    ack_lat = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dly_req", 32'(imem.req), 32'd1);
      chk("dly_addr", imem.addr, 32'h21);
      chk("dly_instr_hold", instr, 32'h14220020);
    end
    @(negedge clk);
    chk("dly_instr_load", instr, 32'h00221820);
    chk("dly_req_drop", 32'(imem.req), 32'd0);
    @(negedge clk);
    chk("dly_no_ret_c6", 32'(retired), 32'd0);
    @(negedge clk);
    chk("dly_retired_c7", 32'(retired), 32'd1);
    @(negedge clk);
    chk("run_fetch_addr", imem.addr, 32'h22);
    repeat (4) @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("run_wb_retired", 32'(retired), 32'd1);
    chk("run_wb_rf_we", 32'(rf_we), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("run_idle_req", 32'(imem.req), 32'd0);
      chk("run_idle_pc", pc, 32'h23);
    end
    ack_lat = 10; run = 1'b1;
    @(negedge clk);
    chk("rstf_req", 32'(imem.req), 32'd1);
    chk("rstf_addr", imem.addr, 32'h23);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstf_req_drop", 32'(imem.req), 32'd0);
    chk("rstf_pc", pc, 32'd0);
    chk("rstf_instr", instr, 32'd0);
    mem[0] = 32'h08000005; mem[5] = 32'h08000005; ack_lat = 0;
    @(negedge clk);
    #1;
    sb.push_back('{32'h5, 1'b0});
    sb.push_back('{32'h5, 1'b0});
`ifndef CPU_SEQ_HALT_EN
    sb.push_back('{32'h5, 1'b0});
    sb.push_back('{32'h5, 1'b0});
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("self_addr0", imem.addr, 32'd0);
    repeat (4) @(negedge clk);
    chk("self_pc5", pc, 32'd5);
    chk("self_addr5", imem.addr, 32'd5);
    repeat (3) @(negedge clk);
    chk("self_retired", 32'(retired), 32'd1);
    chk("self_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
`ifdef CPU_SEQ_HALT_EN
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'd5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("halt_no_req", 32'(imem.req), 32'd0);
      chk("halt_stay", 32'(halted), 32'd1);
    end
`else
    chk("loop_req_c9", 32'(imem.req), 32'd1);
    chk("loop_addr_c9", imem.addr, 32'd5);
    chk("loop_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("loop_req_gap", 32'(imem.req), 32'd0);
    end
    @(negedge clk);
    chk("loop_req_c13", 32'(imem.req), 32'd1);
    chk("loop_pc_c13", pc, 32'd5);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("loop_retired_c16", 32'(retired), 32'd1);
    repeat (2) @(negedge clk);
    chk("loop_park_req", 32'(imem.req), 32'd0);
    chk("loop_park_pc", pc, 32'd5);
`endif
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle sequencer for the single-issue CPU. It owns the program counter and the instruction register, and fetches from instruction memory over a req/ack handshake. It steps each instruction through fixed FETCH/DECODE/EXECUTE/WRITEBACK phases and gates the register-file write strobe. It sits between instruction memory and `cpu_control`: it feeds `instr` to the decoder and consumes the decoder's jump/branch/write-enable outputs plus the ALU result.

## Interface
- `PC_WIDTH`, 32: program-counter width; PC is a word (instruction) index.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; permits starting a new instruction.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_WIDTH  fetch address (= `pc`).
- `imem_ack`  in  1  fetch data valid; may be combinational from `imem_req`.
- `imem_rdata`  in  32  fetched instruction.
- `instr`  out  32  instruction register, drives decoder.
- `dec_jump`  in  1  decoder jump flag.
- `dec_branch`  in  1  decoder branch flag.
- `dec_jump_address`  in  32  decoder jump/branch target (absolute word index).
- `dec_write_enable`  in  1  decoder register-write flag.
- `alu_result`  in  32  ALU output; bit 0 is the branch condition (NEQ).
- `rf_we`  out  1  register-file write strobe.
- `pc`  out  PC_WIDTH  current program counter.
- `retired`  out  1  one-cycle pulse per completed instruction.
- `halted`  out  1  halt indicator (see Configuration).

## Operation
- The state register has 3 bits: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, and HALT (macro only).
- IDLE: if `run`=1, go to FETCH; otherwise stay.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until ack.
  - On the edge with `imem_ack`=1: `instr` <= `imem_rdata`, go to DECODE.
  - `imem_ack` is ignored in every other state.
- DECODE: a single settle cycle for the decoder. Always go to EXECUTE.
- EXECUTE:
  - Register `next_pc` as follows:
    - `dec_jump`=1: `dec_jump_address[PC_WIDTH-1:0]`.
    - else `dec_branch` & `alu_result[0]`: `dec_jump_address[PC_WIDTH-1:0]`.
    - else `pc`+1, wrapping modulo 2^PC_WIDTH.
  - Jump has priority over branch. Go to WRITEBACK.
- WRITEBACK:
  - `rf_we` = `dec_write_enable` & ~`dec_jump` & ~`dec_branch`.
  - `retired`=1.
  - On exit: `pc` <= `next_pc`.
  - Next state is FETCH if `run`=1, else IDLE.
- `run` deassertion mid-instruction never aborts it; the instruction completes through WRITEBACK, then the block parks in IDLE.
- `instr` changes only on a FETCH ack, so decoder outputs are stable through DECODE, EXECUTE and WRITEBACK.

## Timing
- Reset (async assert, sync release):
  - State = IDLE, `pc`=RESET_PC, `instr`=0, `next_pc`=RESET_PC.
  - `imem_req`, `rf_we`, `retired`, `halted` = 0.
  - An outstanding fetch is abandoned and `imem_req` drops immediately.
- All outputs are Moore, decoded from registered state; there are no combinational paths from inputs to outputs.
- Zero-wait memory gives CPI = 4: FETCH, DECODE, EXECUTE, WRITEBACK. Each ack wait cycle adds 1.
- First FETCH is the cycle after the edge at which `run`=1 is sampled in IDLE.
- `pc` updates on the edge leaving WRITEBACK. The next FETCH presents the new address in the following cycle.
- `rf_we` and `retired` are exactly one cycle wide per instruction.

## Configuration
- `CPU_SEQ_HALT_EN` defined:
  - In EXECUTE, if `dec_jump`=1 and the target equals `pc`, WRITEBACK proceeds normally with `retired`=1 and `pc` unchanged.
  - The block then enters HALT and sets `halted`=1.
  - HALT is left only by reset; `run` is ignored.
- `CPU_SEQ_HALT_EN` undefined:
  - No HALT state; `halted` is tied 0.
  - Jump-to-self loops, re-fetching the same address every 4 cycles (zero-wait).

## Test plan
- R-type, zero-wait:
  - Stimulus: reset, `run`=1, `imem_ack` tied to `imem_req`, word 0 = 0x00221820.
  - Required: `imem_req` in the first cycle; `rf_we`=1 and `retired`=1 in cycle 4; `pc`=1 and FETCH at cycle 5.
- Delayed ack:
  - Stimulus: ack 3 cycles after req.
  - Required: `imem_req`=1 and `imem_addr`=0 held for 4 cycles; `instr` unchanged until the ack edge; `retired` at cycle 7.
- J:
  - Stimulus: instr 0x08000010 at pc 0.
  - Required: `rf_we`=0; `pc`=0x10 after WRITEBACK; next `imem_addr`=0x10.
- BNE:
  - Stimulus: instr 0x14220020 with `alu_result`=1, then the same instruction with `alu_result`=0.
  - Required: `pc`=0x20 for the first; `pc`=old+1 for the second; `rf_we`=0 in both.
- `run` and reset:
  - Stimulus: `run` dropped during DECODE.
    - Required: WRITEBACK completes, then IDLE with no `imem_req`.
  - Stimulus: `rst_n` low during a pending FETCH.
    - Required: `imem_req`=0 immediately; `pc`=RESET_PC.
- Jump-to-self:
  - Stimulus: instr 0x08000005 at pc 5.
  - Required with `CPU_SEQ_HALT_EN`: `halted`=1 and no further `imem_req`.
  - Required without it: `pc` stays 5; `imem_req` every 4 cycles; `halted`=0.
